rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter; produces a registered one-hot grant vector.
- Sits directly upstream of the 8-to-3 encoder: grant[7:0] drives the encoder's d input and grant_valid drives its enable input.
- The encoder then yields the index of the current owner.
- Grant is by construction always one-hot or zero, so the encoder never sees an invalid pattern.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this block and checked by elaboration assertion.
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only when the timeout feature is compiled in; must be at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  arbitration enable; low forces a release.
- req  input  8  request vector; bit i = requester i.
- grant  output  8  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  high when grant is non-zero; equals the OR of grant.
- timeout_pulse  output  1  one-cycle pulse on forced revoke; tied 0 when the feature is absent.

Behaviour:
- Reset (synchronous, active-high): grant=0, grant_valid=0, timeout_pulse=0, state=IDLE, ptr=0, hold_cnt=0.
- ptr: 3-bit internal priority pointer. Search order is ptr, ptr+1, … ptr+7, wrapping mod 8.

State IDLE:
- If enable=1 and req!=0: select the first set req bit in search order (index k).
- Next cycle: grant=1<<k, grant_valid=1, state=GRANT, hold_cnt=0.
- Latency from req rising to grant is 1 cycle.
- Otherwise: grant stays 0.

State GRANT (owner k):
- Hold: while enable=1 and req[k]=1, grant stays unchanged and hold_cnt increments, saturating at MAX_HOLD-1.
- Release: if req[k]=0 or enable=0, then next cycle grant=0, grant_valid=0, ptr=(k+1) mod 8, state=IDLE.
- One mandatory idle bubble cycle between grants.
- Other req bits changing during GRANT are ignored.

Boundary conditions:
- Wrap-around: owner 7 releasing sets ptr=0.
- Simultaneous requests are resolved purely by ptr order.
- req going 0 in the same cycle as a new grant is issued: the grant is still issued and released next cycle (granted for 1 cycle).
- reset asserted mid-GRANT: grant drops on the next edge and ptr returns to 0.
- reset has priority over every other event.
- enable low in IDLE: no grant issued; ptr is unchanged.
- grant is never asserted with more than one bit set. Assertion required in simulation.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT with req[k]=1 and hold_cnt==MAX_HOLD-1, the next cycle revokes the grant.
  - On revoke: grant=0, ptr=(k+1) mod 8, state=IDLE, timeout_pulse=1 for exactly that cycle.
  - If the revoked requester keeps requesting, it becomes lowest priority.
  - hold_cnt width is $clog2(MAX_HOLD).
- Undefined:
  - No hold_cnt register; grant is held indefinitely while req[k]=1.
  - timeout_pulse is constant 0.
  - MAX_HOLD is ignored.

Decomposition:
- Package rr_arb_pkg holds:
  - localparam N_REQ=8 and PTR_W=3;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - a function rotate-mask helper.
- One natural sub-module: rr_pick8.
  - Purely combinational.
  - Inputs: req[7:0] and ptr[2:0]. Outputs: onehot[7:0] and any[0].
  - Rotates req right by ptr, applies a fixed priority-first-one, then rotates back.
- The top module holds the FSM, ptr, grant register and the optional counter.

Test Plan:
- Reset then req=8'h00, enable=1 for 5 cycles -> grant=8'h00, grant_valid=0 throughout.
- From reset, req=8'b1000_0001 held -> grant=8'h01 one cycle later; drop req[0] -> grant=0 for 1 cycle, then grant=8'h80.
- Wrap: owner 7 releases while req=8'h81 -> next grant=8'h01 (ptr wrapped to 0).
- All 8 requesters assert req=8'hFF and each drops 2 cycles after being granted -> grant sequence 01,02,04,…,80,01. Each grant is one-hot and each is separated by one idle cycle.
- enable deasserted during grant=8'h10 -> grant=0 next cycle; re-enable with req=8'h10 only -> grant=8'h10 again after 1 cycle. Assert reset mid-grant -> grant=0 and ptr=0 next edge.
- With RR_ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h06 held -> grant=8'h02 for exactly 4 cycles; then timeout_pulse=1 with grant=0 for 1 cycle, then grant=8'h04. Without the macro, grant=8'h02 held for 100 cycles.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants, FSM encoding and rotate/encode helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int PTR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] v, input logic [PTR_W-1:0] s);
        logic [2*N_REQ-1:0] d;
        d = {v, v} >> s;
        return d[N_REQ-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] rot_left(input logic [N_REQ-1:0] v, input logic [PTR_W-1:0] s);
        logic [2*N_REQ-1:0] d;
        d = {v, v} << s;
        return d[2*N_REQ-1:N_REQ];
    endfunction

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (v[i]) idx = PTR_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_pick8.sv
// rr_pick8: combinational round-robin pick; first set req bit at or after ptr, wrapping mod 8.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic             any
);

    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_first;

    // Rotating puts ptr at bit 0, so isolating the lowest set bit gives the winner.
    assign w_rot   = rot_right(req, ptr);
    assign w_first = w_rot & (~w_rot + N_REQ'(1));
    assign onehot  = rot_left(w_first, ptr);
    assign any     = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-requester round-robin arbiter with registered one-hot grant.
// Define RR_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD consecutive cycles.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             timeout_pulse
);

    if (N_REQ != 8) begin : g_nreq_chk
        $error("rr_arbiter_8 requires N_REQ == 8");
    end
    if (MAX_HOLD < 2) begin : g_hold_chk
        $error("rr_arbiter_8 requires MAX_HOLD >= 2");
    end

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_pick;
    logic             w_any;
    logic             w_hold;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_pick),
        .any    (w_any)
    );

    // Owner keeps the grant only while enabled and still requesting; other req bits are ignored.
    assign w_hold = enable & req[r_owner];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_tpulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_hold_cnt <= '0;
            r_tpulse   <= 1'b0;
        end else begin
            r_tpulse <= 1'b0;
            if (r_state == IDLE) begin
                if (enable && w_any) begin
                    r_grant    <= w_pick;
                    r_owner    <= onehot_idx(w_pick);
                    r_hold_cnt <= '0;
                    r_state    <= GRANT;
                end
            end else if (!w_hold || r_hold_cnt == HOLD_LAST) begin
                r_grant  <= '0;
                r_ptr    <= r_owner + PTR_W'(1);
                r_state  <= IDLE;
                r_tpulse <= w_hold;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign timeout_pulse = r_tpulse;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
        end else if (r_state == IDLE) begin
            if (enable && w_any) begin
                r_grant <= w_pick;
                r_owner <= onehot_idx(w_pick);
                r_state <= GRANT;
            end
        end else if (!w_hold) begin
            r_grant <= '0;
            r_ptr   <= r_owner + PTR_W'(1);
            r_state <= IDLE;
        end
    end

    assign timeout_pulse = 1'b0;
`endif

    assign grant       = r_grant;
    assign grant_valid = |r_grant;

    a_grant_onehot0: assert property (@(posedge clk) $onehot0(r_grant));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed scoreboard bench; driver queues hand-computed expectations, monitor checks each cycle.
module tb_rr_arbiter_8;

    typedef struct {
        logic [7:0] g;
        logic       tp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic       grant_valid;
    logic       timeout_pulse;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    rr_arbiter_8 #(
        .MAX_HOLD (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .req           (req),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic en, input logic [7:0] rq, input logic [7:0] eg, input logic etp);
        exp_t e;
        @(negedge clk);
        #1;
        reset  = r;
        enable = en;
        req    = rq;
        e.g    = eg;
        e.tp   = etp;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("grant", grant, e.g);
                check("grant_valid", {7'd0, grant_valid}, {7'd0, e.g != 8'h00});
                check("timeout_pulse", {7'd0, timeout_pulse}, {7'd0, e.tp});
            end
        end
    end

    initial begin
        step(1, 1, 8'h00, 8'h00, 0);
        step(1, 1, 8'hFF, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 8'h00, 0);
        // Two requesters from reset, then wrap through owner 7.
        step(0, 1, 8'h81, 8'h01, 0);
        step(0, 1, 8'h81, 8'h01, 0);
        step(0, 1, 8'h80, 8'h00, 0);
        step(0, 1, 8'h80, 8'h80, 0);
        step(0, 1, 8'h81, 8'h80, 0);
        step(0, 1, 8'h01, 8'h00, 0);
        step(0, 1, 8'h81, 8'h01, 0);
        step(0, 1, 8'h00, 8'h00, 0);
        // All eight requesting, each drops two cycles after its grant.
        step(1, 1, 8'h00, 8'h00, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 8'hFF, 8'h01 << k, 0);
            step(0, 1, 8'hFF, 8'h01 << k, 0);
            step(0, 1, 8'hFF & ~(8'h01 << k), 8'h00, 0);
        end
        step(0, 1, 8'hFF, 8'h01, 0);
        step(0, 1, 8'h00, 8'h00, 0);
        // Enable drop during grant, regrant, then reset mid-grant.
        step(1, 1, 8'h00, 8'h00, 0);
        step(0, 1, 8'h10, 8'h10, 0);
        step(0, 1, 8'h10, 8'h10, 0);
        step(0, 0, 8'h10, 8'h00, 0);
        step(0, 1, 8'h10, 8'h10, 0);
        step(0, 1, 8'h10, 8'h10, 0);
        step(1, 1, 8'h10, 8'h00, 0);
        step(0, 1, 8'h81, 8'h01, 0);
        step(0, 1, 8'h00, 8'h00, 0);
        // Enable low in IDLE leaves ptr at 1.
        step(0, 0, 8'hFF, 8'h00, 0);
        step(0, 0, 8'hFF, 8'h00, 0);
        step(0, 1, 8'h03, 8'h02, 0);
        step(0, 1, 8'h00, 8'h00, 0);
        // Request withdrawn as the grant is issued: single-cycle grant.
        step(0, 1, 8'h04, 8'h04, 0);
        step(0, 1, 8'h00, 8'h00, 0);
        step(0, 1, 8'h00, 8'h00, 0);
        // Long hold on req 1 with req 2 waiting.
        step(1, 1, 8'h00, 8'h00, 0);
        step(0, 1, 8'h06, 8'h02, 0);
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) step(0, 1, 8'h06, 8'h02, 0);
        step(0, 1, 8'h06, 8'h00, 1);
        step(0, 1, 8'h06, 8'h04, 0);
        step(0, 1, 8'h06, 8'h04, 0);
        step(0, 1, 8'h02, 8'h00, 0);
`else
        for (int i = 0; i < 100; i++) step(0, 1, 8'h06, 8'h02, 0);
        step(0, 1, 8'h04, 8'h00, 0);
`endif
        step(0, 1, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
